// File: rtl/mc_controller.sv
// mc_controller: main control FSM for the multicycle MIPS datapath.
// Define MC_CTRL_BNE_EN to add the bne instruction (BNEEX state).
module mc_controller #(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic               zero,
    input  logic               memready,
    output logic               memwrite,
    output logic               iord,
    output logic               irwrite,
    output logic               pcen,
    output logic               regwrite,
    output logic               regdst,
    output logic               memtoreg,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         pcsrc,
    output logic [1:0]         aluop,
    output logic               zeroext,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);
    typedef enum logic [STATE_W-1:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX,
        RTYPEWB, BEQEX, ADDIEX, IMMWB, JEX, ORIEX, BNEEX
    } state_t;
    typedef struct packed {
        logic       iord;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
        logic       zeroext;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       memwrite;
        logic       fetch;
        logic       jmp;
        logic       beq;
        logic       bne;
    } ctl_t;
    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011;
    localparam logic [5:0] OP_R = 6'b000000;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_J = 6'b000010;
`ifdef MC_CTRL_BNE_EN
    localparam logic [5:0] OP_BNE = 6'b000101;
`endif
    state_t cur, nxt;
    ctl_t   ctl;
    logic   hs, bad;
    // Moore fields for a state; memready/zero-dependent terms are applied at the outputs
    function automatic ctl_t dec(state_t s);
        ctl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.alusrcb = 2'b01;
                c.fetch = 1'b1;
            end
            DECODE: c.alusrcb = 2'b11;
            MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            MEMRD: c.iord = 1'b1;
            MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            MEMWR: begin
                c.iord = 1'b1;
                c.memwrite = 1'b1;
            end
            RTYPEEX: begin
                c.alusrca = 1'b1;
                c.aluop = 2'b10;
            end
            RTYPEWB: begin
                c.regdst = 1'b1;
                c.regwrite = 1'b1;
            end
            BEQEX: begin
                c.alusrca = 1'b1;
                c.aluop = 2'b01;
                c.pcsrc = 2'b01;
                c.beq = 1'b1;
            end
            ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            ORIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
                c.aluop = 2'b11;
                c.zeroext = 1'b1;
            end
            IMMWB: c.regwrite = 1'b1;
            JEX: begin
                c.pcsrc = 2'b10;
                c.jmp = 1'b1;
            end
`ifdef MC_CTRL_BNE_EN
            BNEEX: begin
                c.alusrca = 1'b1;
                c.aluop = 2'b01;
                c.pcsrc = 2'b01;
                c.bne = 1'b1;
            end
`endif
            default: c = '0;
        endcase
        return c;
    endfunction
    assign hs = MEM_HANDSHAKE ? memready : 1'b1;
    always_comb begin
        nxt = FETCH;
        bad = 1'b0;
        case (cur)
            FETCH: nxt = hs ? DECODE : FETCH;
            DECODE:
                case (op)
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_R: nxt = RTYPEEX;
                    OP_BEQ: nxt = BEQEX;
                    OP_ADDI: nxt = ADDIEX;
                    OP_ORI: nxt = ORIEX;
                    OP_J: nxt = JEX;
`ifdef MC_CTRL_BNE_EN
                    OP_BNE: nxt = BNEEX;
`endif
                    default: bad = 1'b1;
                endcase
            MEMADR: nxt = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD: nxt = hs ? MEMWB : MEMRD;
            MEMWR: nxt = hs ? FETCH : MEMWR;
            RTYPEEX: nxt = RTYPEWB;
            ADDIEX, ORIEX: nxt = IMMWB;
            default: nxt = FETCH;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cur <= FETCH;
            ctl <= dec(FETCH);
        end else begin
            cur <= nxt;
            ctl <= dec(nxt);
        end
    end
    assign memwrite = ctl.memwrite & ~reset;
    assign irwrite = ctl.fetch & hs & ~reset;
    assign pcen = ~reset & ((ctl.fetch & hs) | ctl.jmp | (ctl.beq & zero) | (ctl.bne & ~zero));
    assign regwrite = ctl.regwrite & ~reset;
    assign illegal = bad & ~reset;
    assign iord = ctl.iord;
    assign regdst = ctl.regdst;
    assign memtoreg = ctl.memtoreg;
    assign alusrca = ctl.alusrca;
    assign alusrcb = ctl.alusrcb;
    assign pcsrc = ctl.pcsrc;
    assign aluop = ctl.aluop;
    assign zeroext = ctl.zeroext;
    assign state = cur;
endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
Main control FSM for the multicycle MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and writeback states. Drives the 2-bit aluop into the downstream ALU decoder, which also receives funct[5:0] from the instruction register. Supports variable-latency memory through a memready handshake.

Parameters:
MEM_HANDSHAKE, 1, 1: memory states hold until memready=1. 0: memready is ignored and treated as 1.
STATE_W, 4, width of the state register and of the state debug port. Must be at least 4.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
op  in  6  opcode from instruction register, instr[31:26]
zero  in  1  ALU zero flag of the current cycle
memready  in  1  memory access completes this cycle
memwrite  out  1  memory write enable
iord  out  1  memory address select: 0=PC, 1=ALUOut
irwrite  out  1  instruction register load
pcen  out  1  PC load enable
regwrite  out  1  register file write enable
regdst  out  1  write register: 0=rt, 1=rd
memtoreg  out  1  writeback data: 0=ALUOut, 1=Data
alusrca  out  1  ALU A: 0=PC, 1=rs
alusrcb  out  2  ALU B: 00=rt, 01=constant 4, 10=SignImm, 11=SignImm<<2
pcsrc  out  2  next PC: 00=ALUResult, 01=ALUOut, 10=jump target
aluop  out  2  to ALU decoder: 00=add, 01=sub, 10=funct, 11=or
zeroext  out  1  immediate extend: 0=sign, 1=zero
illegal  out  1  one-cycle pulse on an unknown opcode
state  out  STATE_W  current state encoding, for debug

Behaviour:
- Outputs are Moore decodes of the state register. The only exceptions are memready gating and the zero-dependent pcen term.
- Any output not listed for a state is 0.
- State encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, IMMWB=10
  - JEX=11, ORIEX=12, BNEEX=13
- Reset:
  - reset=1 at a rising edge sets state to FETCH. This applies in every state, including mid-instruction and mid-memory-wait.
  - While reset=1, memwrite, irwrite, pcen, regwrite and illegal are forced to 0.
  - After release, outputs take their FETCH values.
- FETCH:
  - Outputs: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=memready, pcen=memready.
  - Stays in FETCH while memready=0. Goes to DECODE when memready=1.
- DECODE:
  - Outputs: alusrca=0, alusrcb=11, aluop=00 (branch target into ALUOut).
  - Next state by op:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 -> RTYPEEX
    - 000100 -> BEQEX
    - 001000 -> ADDIEX
    - 001101 -> ORIEX
    - 000010 -> JEX
    - 000101 -> BNEEX, only when MC_CTRL_BNE_EN is defined
    - any other op -> FETCH, with illegal=1 for this DECODE cycle only
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Goes to MEMRD if op=lw, otherwise to MEMWR.
- MEMRD:
  - Outputs: iord=1.
  - Holds until memready=1, then goes to MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. Goes to FETCH.
- MEMWR:
  - Outputs: iord=1, memwrite=1.
  - memwrite stays asserted for every wait cycle.
  - Goes to FETCH on memready=1.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=10. Goes to RTYPEWB.
- RTYPEWB: regdst=1, memtoreg=0, regwrite=1. Goes to FETCH.
- BEQEX:
  - Outputs: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, pcen=zero.
  - Goes to FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00, zeroext=0. Goes to IMMWB.
- ORIEX: alusrca=1, alusrcb=10, aluop=11, zeroext=1. Goes to IMMWB.
- IMMWB: regdst=0, memtoreg=0, regwrite=1. Goes to FETCH.
- JEX: pcsrc=10, pcen=1. Goes to FETCH.
- Unused state encodings: all enables are 0 and the next state is FETCH.
- Instruction latency in cycles, with memready tied to 1:
  - lw 5; sw 4; R-type, addi and ori 4; beq, bne and j 3.
- Each extra cycle with memready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- memready is sampled only in FETCH, MEMRD and MEMWR. It is ignored in all other states.

Optional Feature:
- Macro: MC_CTRL_BNE_EN.
- Defined:
  - op 000101 in DECODE goes to BNEEX.
  - BNEEX outputs: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, pcen=~zero. Then goes to FETCH.
- Undefined:
  - BNEEX does not exist.
  - op 000101 is treated as illegal: illegal pulses and the FSM returns to FETCH.

Test Plan:
- Reset: reset=1 for 2 cycles in arbitrary states, then release with memready=1 -> state=0; irwrite=1, pcen=1, alusrcb=01, aluop=00; all other write enables 0.
- lw, op=100011, memready=1 -> states 0,1,2,3,4,0 over 5 cycles. In MEMADR: alusrcb=10, aluop=00. In MEMWB: regwrite=1, memtoreg=1, regdst=0.
- sw, op=101011, memready=0 for 3 cycles in MEMWR -> memwrite=1 and iord=1 for 4 consecutive cycles, then state=0. Also hold memready=0 for 2 cycles in FETCH -> irwrite stays 0 until memready=1.
- beq, op=000100: with zero=1 -> in BEQEX pcen=1, pcsrc=01, aluop=01. With zero=0 -> pcen=0. Both return to FETCH.
- ori, op=001101 -> ORIEX with aluop=11, zeroext=1, then IMMWB with regwrite=1, regdst=0. addi, op=001000 -> aluop=00, zeroext=0.
- op=111111, and op=000101 with MC_CTRL_BNE_EN undefined -> illegal=1 for exactly 1 cycle in DECODE, next state=0, regwrite and memwrite never asserted. With the macro defined, op=000101 and zero=0 -> BNEEX with pcen=1.
